// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: shared constants and helpers for the seven-segment scan
// drivers and the scan decoder (active-low segment patterns gfedcba,
// active-low digit enables, decoder FSM state type, BCD-to-binary helper).
package sevenseg_pkg;

  // Active-low segment patterns, bit 0 = a ... bit 6 = g
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  // Active-low digit enables
  localparam logic [3:0] AN_THOU = 4'b0111;
  localparam logic [3:0] AN_HUND = 4'b1011;
  localparam logic [3:0] AN_TENS = 4'b1101;
  localparam logic [3:0] AN_UNIT = 4'b1110;

  // Nibble reported for a pattern that is not a decimal digit
  localparam logic [3:0] BCD_INVALID = 4'hF;

  typedef enum logic {
    COLLECT = 1'b0,
    CONV    = 1'b1
  } state_t;

  // Four BCD digits to binary using only shifts and adds:
  // 1000 = 512+256+128+64+32+8, 100 = 64+32+4, 10 = 8+2.
  function automatic logic [13:0] bcd4_to_bin(input logic [15:0] d);
    logic [13:0] d3;
    logic [13:0] d2;
    logic [13:0] d1;
    logic [13:0] d0;
    d3 = {10'd0, d[15:12]};
    d2 = {10'd0, d[11:8]};
    d1 = {10'd0, d[7:4]};
    d0 = {10'd0, d[3:0]};
    return (d3 << 9) + (d3 << 8) + (d3 << 7) + (d3 << 6) + (d3 << 5) + (d3 << 3)
         + (d2 << 6) + (d2 << 5) + (d2 << 2)
         + (d1 << 3) + (d1 << 1)
         + d0;
  endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// seg7_to_bcd: combinational decode of an active-low gfedcba pattern to a
// BCD nibble. Any pattern that is not one of the ten digits reports
// legal = 0 and nibble BCD_INVALID.
module seg7_to_bcd
  import sevenseg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       legal
);

  // Pattern lookup; everything outside the ten digits is a code error
  always_comb begin
    bcd   = BCD_INVALID;
    legal = 1'b1;
    case (seg)
      SEG_0:   bcd = 4'd0;
      SEG_1:   bcd = 4'd1;
      SEG_2:   bcd = 4'd2;
      SEG_3:   bcd = 4'd3;
      SEG_4:   bcd = 4'd4;
      SEG_5:   bcd = 4'd5;
      SEG_6:   bcd = 4'd6;
      SEG_7:   bcd = 4'd7;
      SEG_8:   bcd = 4'd8;
      SEG_9:   bcd = 4'd9;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// sevenseg_scan_decoder: passive observer of a multiplexed active-low
// 4-digit seven-segment bus. Each {an, seg} pattern must be stable for
// STABLE_CYCLES samples to be accepted; four accepted slots form a frame
// that is published on digits/value with a one-cycle valid pulse.
//
// Handshake: valid is a one-cycle strobe with no ready; digits/value are
// updated on the same edge valid rises and hold until the next good frame.
//
// Optional macro SEGDEC_INPUT_SYNC_EN: when defined, an/seg pass through a
// 2-flop synchronizer (reset to all-ones) ahead of the stability filter,
// adding 2 cycles to every latency.
module sevenseg_scan_decoder
  import sevenseg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  input  logic        err_clr,
  output logic [15:0] digits,
  output logic [13:0] value,
  output logic        valid,
  output logic        err,
  output state_t      dbg_state,
  output logic [3:0]  dbg_seen
);

  localparam logic [15:0] STABLE_W  = 16'(STABLE_CYCLES);
  localparam logic [15:0] STABLE_M1 = 16'(STABLE_CYCLES - 1);

  logic [3:0] an_s;
  logic [6:0] seg_s;

`ifdef SEGDEC_INPUT_SYNC_EN
  logic [10:0] sync_q1;
  logic [10:0] sync_q2;

  // Two-flop synchronizer for asynchronous bus sources
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '1;
      sync_q2 <= '1;
    end else begin
      sync_q1 <= {an, seg};
      sync_q2 <= sync_q1;
    end
  end

  assign {an_s, seg_s} = sync_q2;
`else
  assign an_s  = an;
  assign seg_s = seg;
`endif

  // ---------------------------------------------------------------
  // Stability filter
  // ---------------------------------------------------------------
  logic [10:0] prev_q;
  logic [15:0] run_q;
  logic        changed;
  logic        accept;

  assign changed = ({an_s, seg_s} != prev_q);
  // The edge that takes the run from STABLE-1 to STABLE is the one acceptance
  assign accept  = !changed && (run_q == STABLE_M1);

  // Previous sample and saturating run-length counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '1;
      run_q  <= '0;
    end else begin
      prev_q <= {an_s, seg_s};
      if (changed) begin
        run_q <= 16'd1;
      end else if (run_q != STABLE_W) begin
        run_q <= run_q + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------
  // Slot qualification and segment decode
  // ---------------------------------------------------------------
  logic       an_ok;
  logic [1:0] slot_idx;
  logic [3:0] slot_bit;
  logic [3:0] bcd;
  logic       legal;

  // Only the four one-hot-low enables name a slot; others are ignored
  always_comb begin
    an_ok    = 1'b1;
    slot_idx = 2'd0;
    case (an_s)
      AN_THOU: slot_idx = 2'd3;
      AN_HUND: slot_idx = 2'd2;
      AN_TENS: slot_idx = 2'd1;
      AN_UNIT: slot_idx = 2'd0;
      default: an_ok = 1'b0;
    endcase
  end

  assign slot_bit = an_ok ? (4'b0001 << slot_idx) : 4'b0000;

  seg7_to_bcd u_seg7_to_bcd (
    .seg   (seg_s),
    .bcd   (bcd),
    .legal (legal)
  );

  logic       acc_any;
  logic       acc_good;
  logic       acc_bad;
  logic [3:0] acc_mask;
  logic [3:0] seen_next;

  assign acc_any   = accept && an_ok;
  assign acc_good  = acc_any && legal;
  assign acc_bad   = acc_any && !legal;
  assign acc_mask  = acc_any ? slot_bit : 4'b0000;

  // ---------------------------------------------------------------
  // Frame FSM and registered outputs
  // ---------------------------------------------------------------
  state_t          state_q;
  logic [3:0]      seen_q;
  logic            frame_bad_q;
  logic [3:0][3:0] slots_q;

  assign seen_next = seen_q | acc_mask;

  // Collect slots into a frame, then publish it for one CONV cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      seen_q      <= '0;
      frame_bad_q <= 1'b0;
      slots_q     <= '0;
      digits      <= '0;
      value       <= '0;
      valid       <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (acc_good) begin
        slots_q[slot_idx] <= bcd;
      end
      case (state_q)
        COLLECT: begin
          seen_q <= seen_next;
          if (acc_bad) begin
            frame_bad_q <= 1'b1;
          end
          if (seen_next == 4'b1111) begin
            state_q <= CONV;
          end
        end
        CONV: begin
          if (!frame_bad_q) begin
            digits <= slots_q;
            value  <= bcd4_to_bin(slots_q);
            valid  <= 1'b1;
          end
          // A slot accepted during CONV opens the next frame
          seen_q      <= acc_mask;
          frame_bad_q <= acc_bad;
          state_q     <= COLLECT;
        end
        default: begin
          state_q <= COLLECT;
        end
      endcase
    end
  end

  // Sticky code-error flag; a new error wins over a same-edge clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (acc_bad) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

  assign dbg_state = state_q;
  assign dbg_seen  = seen_q;

endmodule
